// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : ALUFun code constants and shared types for the ALU share arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALUFun codes as understood by the shared ALU (forwarded untranslated).
  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_SUB   = 6'b000001;
  localparam logic [5:0] ALU_AND   = 6'b011000;
  localparam logic [5:0] ALU_OR    = 6'b011110;
  localparam logic [5:0] ALU_XOR   = 6'b010110;
  localparam logic [5:0] ALU_NOR   = 6'b010001;
  localparam logic [5:0] ALU_PASSA = 6'b011010;
  localparam logic [5:0] ALU_SLL   = 6'b100000;
  localparam logic [5:0] ALU_SRL   = 6'b100001;
  localparam logic [5:0] ALU_SRA   = 6'b100011;

  // Width of the requester id carried through the issue stage.
  localparam int PORT_ID_W = 1;

  typedef logic [PORT_ID_W-1:0] port_id_t;

  // One ALU operation as captured from a requester.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fun;
    logic        sign;
  } alu_op_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_share_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb_if
// Purpose  : Request/response handshake bundle for both ALU requesters.
//            master = requester side, slave = arbiter side.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_share_arb_if;

  // Port 0: main execute path
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [5:0]  req0_fun;
  logic        req0_sign;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_z;

  // Port 1: address-gen / branch-compare path
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [5:0]  req1_fun;
  logic        req1_sign;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_z;

  modport master (
    output req0_valid, req0_a, req0_b, req0_fun, req0_sign, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_fun, req1_sign, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_z,
    input  req1_ready, rsp1_valid, rsp1_z
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_fun, req0_sign, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_fun, req1_sign, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_z,
    output req1_ready, rsp1_valid, rsp1_z
  );

endinterface : alu_share_arb_if
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-requester arbiter, round-robin or fixed (port 0 first).
//            o_prio0 tells the caller which port currently holds priority so
//            ready can be formed without looking at the requester's own valid.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant,
  output logic       o_prio0
);

  // 0: port 0 favoured, 1: port 1 favoured
  logic r_ptr;

  // After every accept, hand priority to the port that was not granted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_accept) begin
      r_ptr <= o_grant[0];
    end
  end

  assign o_prio0    = (FIXED_PRIO != 0) ? 1'b1 : ~r_ptr;
  assign o_grant[0] = i_req[0] & (o_prio0  | ~i_req[1]);
  assign o_grant[1] = i_req[1] & (~o_prio0 | ~i_req[0]);

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb
// Purpose  : Shares one combinational 32-bit ALU between two requesters.
//            Accept -> issue register driving the ALU -> per-port response
//            slot. Two-cycle latency, one op in flight per port.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic           clk,
  input  logic           reset,
  alu_share_arb_if.slave bus,
  output logic [31:0]    alu_a,
  output logic [31:0]    alu_b,
  output logic [5:0]     alu_fun,
  output logic           alu_sign,
  input  logic [31:0]    alu_z
);

  logic [1:0]  w_req_valid;
  logic [1:0]  w_rsp_ready;
  logic [1:0]  w_elig;
  logic [1:0]  w_req;
  logic [1:0]  w_grant;
  logic [1:0]  w_ready;
  logic        w_prio0;
  logic        w_accept;
  alu_op_t     w_op [2];

  logic        r_iss_valid;
  port_id_t    r_iss_port;
  alu_op_t     r_iss_op;
  logic [1:0]  r_rsp_valid;
  logic [31:0] r_rsp_z [2];

  // Flatten the per-port bundle into indexable vectors
  always_comb begin
    w_req_valid = {bus.req1_valid, bus.req0_valid};
    w_rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
    w_op[0]     = '{a: bus.req0_a, b: bus.req0_b, fun: bus.req0_fun, sign: bus.req0_sign};
    w_op[1]     = '{a: bus.req1_a, b: bus.req1_b, fun: bus.req1_fun, sign: bus.req1_sign};
  end

  // A port may issue only when nothing of its own is in the issue stage and
  // its response slot is empty or being drained this cycle
  always_comb begin
    w_elig = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_elig[i] = ~(r_iss_valid & (r_iss_port == port_id_t'(i)))
                & (~r_rsp_valid[i] | w_rsp_ready[i]);
    end
  end

  assign w_req    = w_elig & w_req_valid;
  assign w_accept = |w_grant;

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk      (clk),
    .rst      (reset),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_grant  (w_grant),
    .o_prio0  (w_prio0)
  );

  // Ready uses the priority owner and the other port's request only, so it
  // never depends on the port's own valid
  assign w_ready[0] = w_elig[0] & (w_prio0  | ~w_req[1]);
  assign w_ready[1] = w_elig[1] & (~w_prio0 | ~w_req[0]);

  // Issue stage: registers the granted op; operands hold while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_iss_valid <= 1'b0;
      r_iss_port  <= '0;
      r_iss_op    <= '0;
    end else if (w_accept) begin
      r_iss_valid <= 1'b1;
      r_iss_port  <= port_id_t'(w_grant[1]);
      r_iss_op    <= w_grant[1] ? w_op[1] : w_op[0];
    end else begin
      r_iss_valid <= 1'b0;
    end
  end

  // Response slots: capture ALU result for the issuing port; refill wins
  // over a same-cycle consume
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_rsp_z[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_iss_valid && (r_iss_port == port_id_t'(i))) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_z[i]     <= alu_z;
        end else if (w_rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign alu_a    = r_iss_op.a;
  assign alu_b    = r_iss_op.b;
  assign alu_fun  = r_iss_op.fun;
  assign alu_sign = r_iss_op.sign;

  assign bus.req0_ready = w_ready[0];
  assign bus.req1_ready = w_ready[1];
  assign bus.rsp0_valid = r_rsp_valid[0];
  assign bus.rsp1_valid = r_rsp_valid[1];
  assign bus.rsp0_z     = r_rsp_z[0];
  assign bus.rsp1_z     = r_rsp_z[1];

endmodule : alu_share_arb
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arb
// Purpose  : Bench for alu_share_arb. Drives a round-robin and a fixed-
//            priority instance with the same stimulus; each has its own
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // Shared stimulus
  logic        in_v  [2];
  logic [31:0] in_a  [2];
  logic [31:0] in_b  [2];
  logic [5:0]  in_f  [2];
  logic        in_s  [2];
  logic        in_rr [2];

  alu_share_arb_if bus_rr ();
  alu_share_arb_if bus_fp ();

  logic [31:0] alu_a [2];
  logic [31:0] alu_b [2];
  logic [31:0] alu_z [2];
  logic [5:0]  alu_fun [2];
  logic        alu_sign [2];

  logic [1:0]  rdy [2];
  logic [1:0]  rv  [2];
  logic [31:0] rz  [2][2];

  // Behavioural ALU standing in for the real one
  function automatic logic [31:0] alu_ref(input logic [31:0] fa, input logic [31:0] fb,
                                          input logic [5:0] ff, input logic fs);
    case (ff)
      ALU_ADD:   return fa + fb;
      ALU_SUB:   return fa - fb;
      ALU_AND:   return fa & fb;
      ALU_OR:    return fa | fb;
      ALU_XOR:   return fa ^ fb;
      ALU_NOR:   return ~(fa | fb);
      ALU_PASSA: return fa;
      ALU_SLL:   return fb << fa[4:0];
      ALU_SRL:   return fb >> fa[4:0];
      ALU_SRA:   return 32'($signed(fb) >>> fa[4:0]);
      default:   return fs ? 32'($signed(fa) < $signed(fb)) : 32'(fa < fb);
    endcase
  endfunction

  assign alu_z[0] = alu_ref(alu_a[0], alu_b[0], alu_fun[0], alu_sign[0]);
  assign alu_z[1] = alu_ref(alu_a[1], alu_b[1], alu_fun[1], alu_sign[1]);

  assign bus_rr.req0_valid = in_v[0];  assign bus_fp.req0_valid = in_v[0];
  assign bus_rr.req0_a     = in_a[0];  assign bus_fp.req0_a     = in_a[0];
  assign bus_rr.req0_b     = in_b[0];  assign bus_fp.req0_b     = in_b[0];
  assign bus_rr.req0_fun   = in_f[0];  assign bus_fp.req0_fun   = in_f[0];
  assign bus_rr.req0_sign  = in_s[0];  assign bus_fp.req0_sign  = in_s[0];
  assign bus_rr.rsp0_ready = in_rr[0]; assign bus_fp.rsp0_ready = in_rr[0];
  assign bus_rr.req1_valid = in_v[1];  assign bus_fp.req1_valid = in_v[1];
  assign bus_rr.req1_a     = in_a[1];  assign bus_fp.req1_a     = in_a[1];
  assign bus_rr.req1_b     = in_b[1];  assign bus_fp.req1_b     = in_b[1];
  assign bus_rr.req1_fun   = in_f[1];  assign bus_fp.req1_fun   = in_f[1];
  assign bus_rr.req1_sign  = in_s[1];  assign bus_fp.req1_sign  = in_s[1];
  assign bus_rr.rsp1_ready = in_rr[1]; assign bus_fp.rsp1_ready = in_rr[1];

  assign rdy[0]   = {bus_rr.req1_ready, bus_rr.req0_ready};
  assign rdy[1]   = {bus_fp.req1_ready, bus_fp.req0_ready};
  assign rv[0]    = {bus_rr.rsp1_valid, bus_rr.rsp0_valid};
  assign rv[1]    = {bus_fp.rsp1_valid, bus_fp.rsp0_valid};
  assign rz[0][0] = bus_rr.rsp0_z;     assign rz[0][1] = bus_rr.rsp1_z;
  assign rz[1][0] = bus_fp.rsp0_z;     assign rz[1][1] = bus_fp.rsp1_z;

  alu_share_arb #(.FIXED_PRIO(0)) u_dut_rr (
    .clk(clk), .reset(reset), .bus(bus_rr),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_fun(alu_fun[0]),
    .alu_sign(alu_sign[0]), .alu_z(alu_z[0])
  );

  alu_share_arb #(.FIXED_PRIO(1)) u_dut_fp (
    .clk(clk), .reset(reset), .bus(bus_fp),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_fun(alu_fun[1]),
    .alu_sign(alu_sign[1]), .alu_z(alu_z[1])
  );

  // Reference model, per instance d and port x:
  // busy = op accepted and result not yet consumed; acc = accept cycle.
  bit          busy [2][2];
  int          acc  [2][2];
  logic [31:0] ez   [2][2];
  int          last [2];      // last granted port
  logic [31:0] la [2];
  logic [31:0] lb [2];
  logic [5:0]  lf [2];
  logic        ls [2];
  int          cyc;
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s : got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last[d] = 1;
      la[d] = '0; lb[d] = '0; lf[d] = '0; ls[d] = 1'b0;
      for (int x = 0; x < 2; x++) busy[d][x] = 1'b0;
    end
  endtask

  task automatic drive(input int x, input logic vv, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [5:0] ff, input logic ss);
    in_v[x] = vv; in_a[x] = aa; in_b[x] = bb; in_f[x] = ff; in_s[x] = ss;
  endtask

  function automatic logic [5:0] pick_fun();
    case ($urandom_range(0, 11))
      0: return ALU_ADD;   1: return ALU_SUB;  2: return ALU_AND;
      3: return ALU_OR;    4: return ALU_XOR;  5: return ALU_NOR;
      6: return ALU_PASSA; 7: return ALU_SLL;  8: return ALU_SRL;
      9: return ALU_SRA;   default: return 6'($urandom);
    endcase
  endfunction

  // One clock: check outputs against the model, advance the model, move on
  // to the next falling edge
  task automatic step();
    bit landed [2];
    bit elig   [2];
    bit req    [2];
    bit er     [2];
    bit p0;
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int x = 0; x < 2; x++) begin
        landed[x] = busy[d][x] && (cyc >= acc[d][x] + 2);
        elig[x]   = !busy[d][x] || (landed[x] && in_rr[x]);
        req[x]    = elig[x] && in_v[x];
      end
      p0    = (d == 1) || (last[d] == 1);
      er[0] = elig[0] && (p0 || !req[1]);
      er[1] = elig[1] && (!p0 || !req[0]);
      for (int x = 0; x < 2; x++) begin
        check($sformatf("d%0d_req%0d_ready", d, x), 32'(rdy[d][x]), 32'(er[x]));
        check($sformatf("d%0d_rsp%0d_valid", d, x), 32'(rv[d][x]), 32'(landed[x]));
        if (landed[x]) check($sformatf("d%0d_rsp%0d_z", d, x), rz[d][x], ez[d][x]);
      end
      check($sformatf("d%0d_alu_a", d), alu_a[d], la[d]);
      check($sformatf("d%0d_alu_b", d), alu_b[d], lb[d]);
      check($sformatf("d%0d_alu_fun", d), 32'(alu_fun[d]), 32'(lf[d]));
      check($sformatf("d%0d_alu_sign", d), 32'(alu_sign[d]), 32'(ls[d]));
      for (int x = 0; x < 2; x++) begin
        if (landed[x] && in_rr[x]) busy[d][x] = 1'b0;
      end
      for (int x = 0; x < 2; x++) begin
        if (in_v[x] && er[x]) begin
          busy[d][x] = 1'b1;
          acc[d][x]  = cyc;
          ez[d][x]   = alu_ref(in_a[x], in_b[x], in_f[x], in_s[x]);
          last[d]    = x;
          la[d] = in_a[x]; lb[d] = in_b[x]; lf[d] = in_f[x]; ls[d] = in_s[x];
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Hold reset across two edges, then confirm every output is at its reset value
  task automatic apply_reset();
    reset = 1'b1;
    in_v[0] = 1'b0; in_v[1] = 1'b0; in_rr[0] = 1'b1; in_rr[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_d%0d_rsp_valid", d), 32'(rv[d]), 32'd0);
      check($sformatf("rst_d%0d_rsp0_z", d), rz[d][0], 32'd0);
      check($sformatf("rst_d%0d_rsp1_z", d), rz[d][1], 32'd0);
      check($sformatf("rst_d%0d_alu_ab", d), alu_a[d] | alu_b[d], 32'd0);
      check($sformatf("rst_d%0d_alu_fun_sign", d), {25'd0, alu_fun[d], alu_sign[d]}, 32'd0);
    end
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    for (int x = 0; x < 2; x++) drive(x, 1'b0, '0, '0, '0, 1'b0);
    model_reset();
    apply_reset();

    // Single port-0 ADD, port 1 idle
    drive(0, 1'b1, 32'd5, 32'd7, ALU_ADD, 1'b0);
    step();
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    check("t1_alu_a", alu_a[0], 32'd5);
    check("t1_alu_b", alu_b[0], 32'd7);
    step();
    check("t1_rsp0_z", rz[0][0], 32'd12);
    check("t1_rsp_valid", 32'(rv[0]), 32'd1);
    step();

    // Contention from reset: port 0 first, then port 1, then alternation
    apply_reset();
    drive(0, 1'b1, 32'd10, 32'd3, ALU_SUB, 1'b0);
    drive(1, 1'b1, 32'd4,  32'd1, ALU_SLL, 1'b0);
    #1 check("t2_first_grant", 32'(rdy[0]), 32'd1);
    step();
    #1 check("t2_second_grant", 32'(rdy[0]), 32'd2);
    step();
    check("t2_rsp0_z", rz[0][0], 32'd7);
    step();
    check("t2_rsp1_z", rz[0][1], 32'd16);
    repeat (8) step();

    // Port 0 back-pressured while port 1 keeps going
    in_rr[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b1, $urandom, $urandom, pick_fun(), 1'($urandom));
      drive(1, 1'b1, $urandom, $urandom, pick_fun(), 1'($urandom));
      step();
    end
    in_rr[0] = 1'b1;
    repeat (3) step();

    // Pending result drained in the same cycle the next op is accepted
    apply_reset();
    in_rr[0] = 1'b0;
    drive(0, 1'b1, 32'd1, 32'd2, ALU_ADD, 1'b0);
    step();
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    repeat (3) step();
    check("t4_held_z", rz[0][0], 32'd3);
    in_rr[0] = 1'b1;
    drive(0, 1'b1, 32'h0000_00FF, 32'h0000_000F, ALU_XOR, 1'b0);
    step();
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    step();
    check("t4_refill_z", rz[0][0], 32'h0000_00F0);
    check("t4_refill_valid", 32'(rv[0][0]), 32'd1);
    step();

    // Reset one cycle after a port-1 accept discards the op
    drive(1, 1'b1, 32'hDEAD_BEEF, 32'd0, ALU_PASSA, 1'b0);
    step();
    drive(1, 1'b0, '0, '0, '0, 1'b0);
    apply_reset();
    repeat (3) step();
    drive(0, 1'b1, 32'd9, 32'd9, ALU_AND, 1'b0);
    drive(1, 1'b1, 32'd9, 32'd9, ALU_OR, 1'b0);
    #1 check("t6_post_reset_grant", 32'(rdy[0]), 32'd1);
    step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      for (int x = 0; x < 2; x++) begin
        drive(x, 1'($urandom_range(0, 9) < 7), $urandom,
              ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
              pick_fun(), 1'($urandom));
        in_rr[x] = ($urandom_range(0, 9) < 6);
      end
      if (i == 300) apply_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_share_arb
`default_nettype wire
